// File: rtl/lu_row_buf.sv
// lu_row_buf: working-matrix row store feeding lu; host row load, 1-cycle row reads, lu write-back.
module lu_row_buf #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [SIZE*2*WIDTH-1:0]   ld_row_i,
    input  logic                      ld_valid_i,
    output logic                      ld_ready_o,
    output logic                      start_o,
    input  logic                      lu_busy_i,
    input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
    input  logic                      rd_valid_i,
    output logic [SIZE*2*WIDTH-1:0]   rd_row_o,
    output logic [$clog2(SIZE)-1:0]   rd_addr_o,
    output logic                      rd_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]   wr_row_i,
    input  logic                      wr_valid_i,
    input  logic [$clog2(SIZE)-1:0]   wr_addr_i,
    output logic                      wr_ready_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int RW = SIZE * 2 * WIDTH;
    localparam int AW = $clog2(SIZE);

    typedef enum logic [1:0] {LOAD, START, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q;
    logic            busy_seen_q;
    logic            ld_ready_q;
    logic            err_q;
    logic [RW-1:0]   mem [SIZE];
    logic            ld_fire, wr_fire, mem_we;
    logic [AW-1:0]   mem_wa;
    logic [RW-1:0]   mem_wd;

    assign ld_ready_o = ld_ready_q;
    assign wr_ready_o = state_q != LOAD;
    assign start_o    = state_q == START;
    assign done_o     = state_q == DONE;
    assign err_o      = err_q;
    assign ld_fire    = ld_valid_i && ld_ready_o;
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign mem_we     = rst_ni && (ld_fire || wr_fire);
    assign mem_wa     = ld_fire ? cnt_q : wr_addr_i;
    assign mem_wd     = ld_fire ? ld_row_i : wr_row_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    state_d = (ld_fire && cnt_q == AW'(SIZE - 1)) ? START : LOAD;
            START:   state_d = RUN;
            RUN:     state_d = (busy_seen_q && !lu_busy_i) ? DONE : RUN;
            DONE:    state_d = ld_valid_i ? LOAD : DONE;
            default: state_d = LOAD;
        endcase
        if (flush_i) state_d = LOAD;
    end

    // ld_ready tracks the LOAD state one register behind reset so it stays low while in reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            busy_seen_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_row_o    <= '0;
            rd_addr_o   <= '0;
        end else begin
            state_q     <= state_d;
            ld_ready_q  <= state_d == LOAD;
            cnt_q       <= flush_i ? '0 : cnt_q + AW'(ld_fire);
            busy_seen_q <= (flush_i || state_q != RUN) ? 1'b0 : (busy_seen_q | lu_busy_i);
            err_q       <= err_q | (wr_valid_i && state_q != RUN);
            rd_valid_o  <= rd_valid_i;
            if (rd_valid_i) begin
                rd_row_o  <= mem[rd_addr_i];
                rd_addr_o <= rd_addr_i;
            end
        end
    end

    // Reads sample mem before this edge's write lands, giving read-before-write
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end
endmodule

// File: tb/tb_lu_row_buf.sv
// tb_lu_row_buf: table-driven cycle vectors plus hand sequences for err, flush and reset.
module tb_lu_row_buf;
    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int RW    = SIZE * 2 * WIDTH;
    localparam int AW    = $clog2(SIZE);

    logic          clk_i = 1'b0;
    logic          rst_ni, flush_i, ld_valid_i, ld_ready_o, start_o, lu_busy_i;
    logic [RW-1:0] ld_row_i, rd_row_o, wr_row_i;
    logic [AW-1:0] rd_addr_i, rd_addr_o, wr_addr_i;
    logic          rd_valid_i, rd_valid_o, wr_valid_i, wr_ready_o, done_o, err_o;

    int checks = 0;
    int failures = 0;
    logic [RW-1:0] rows [9];

    typedef struct {
        string n;
        bit    fl;
        int    ld;
        bit    busy;
        int    rd;
        int    wa;
        int    ws;
        bit    ldr, st, wrr, dn, er;
        int    ra, rs;
    } vec_t;

    vec_t vq[$];

    lu_row_buf #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .ld_row_i(ld_row_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .start_o(start_o), .lu_busy_i(lu_busy_i),
        .rd_addr_i(rd_addr_i), .rd_valid_i(rd_valid_i),
        .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
        .wr_row_i(wr_row_i), .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i),
        .wr_ready_o(wr_ready_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [RW-1:0] mk_row(int i, int salt);
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) begin
            r[j*2*WIDTH +: WIDTH]         = $realtobits(real'(i + j + 1 + salt));
            r[j*2*WIDTH + WIDTH +: WIDTH] = $realtobits(real'(salt));
        end
        return r;
    endfunction

    function automatic vec_t mk(string n, bit fl, int ld, bit busy, int rd, int wa, int ws,
                                bit ldr, bit st, bit wrr, bit dn, bit er, int ra, int rs);
        vec_t v;
        v.n = n; v.fl = fl; v.ld = ld; v.busy = busy; v.rd = rd; v.wa = wa; v.ws = ws;
        v.ldr = ldr; v.st = st; v.wrr = wrr; v.dn = dn; v.er = er; v.ra = ra; v.rs = rs;
        return v;
    endfunction

    task automatic chk(string n, logic [RW-1:0] a, logic [RW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input vec_t v);
        flush_i    = v.fl;
        ld_valid_i = v.ld >= 0;
        ld_row_i   = v.ld >= 0 ? rows[v.ld] : '0;
        lu_busy_i  = v.busy;
        rd_valid_i = v.rd >= 0;
        rd_addr_i  = AW'(v.rd >= 0 ? v.rd : 0);
        wr_valid_i = v.wa >= 0;
        wr_addr_i  = AW'(v.wa >= 0 ? v.wa : 0);
        wr_row_i   = rows[v.ws];
        @(negedge clk_i);
        chk({v.n, "/ld_ready"}, ld_ready_o, v.ldr);
        chk({v.n, "/start"}, start_o, v.st);
        chk({v.n, "/wr_ready"}, wr_ready_o, v.wrr);
        chk({v.n, "/done"}, done_o, v.dn);
        chk({v.n, "/err"}, err_o, v.er);
        chk({v.n, "/rd_valid"}, rd_valid_o, v.rs >= 0);
        if (v.rs >= 0) begin
            chk({v.n, "/rd_addr"}, rd_addr_o, v.ra);
            chk({v.n, "/rd_row"}, rd_row_o, rows[v.rs]);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            rows[i]     = mk_row(i, 0);
            rows[4 + i] = mk_row(i, 200);
        end
        rows[8] = mk_row(0, 100);

        // load r0..r3, start, reads, read-before-write, busy handshake, DONE exit
        for (int i = 0; i < SIZE; i++)
            vq.push_back(mk($sformatf("ld%0d", i), 0, i, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        vq.push_back(mk("start",   0, -1, 0, -1, -1, 0, 0, 1, 1, 0, 0, 0, -1));
        vq.push_back(mk("rd2_req", 0, -1, 0,  2, -1, 0, 0, 0, 1, 0, 0, 0, -1));
        vq.push_back(mk("rd2",     0, -1, 0,  0, -1, 0, 0, 0, 1, 0, 0, 2, 2));
        vq.push_back(mk("rd0",     0, -1, 0,  1, -1, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk("rd1",     0, -1, 0,  3, -1, 0, 0, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk("rd3",     0, -1, 0,  1,  1, 8, 0, 0, 1, 0, 0, 3, 3));
        vq.push_back(mk("rbw_old", 0, -1, 0,  1, -1, 0, 0, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk("rbw_new", 0, -1, 1, -1, -1, 0, 0, 0, 1, 0, 0, 1, 8));
        for (int i = 0; i < 9; i++)
            vq.push_back(mk("busy", 0, -1, 1, -1, -1, 0, 0, 0, 1, 0, 0, 0, -1));
        vq.push_back(mk("busy_fall", 0, -1, 0, -1, -1, 0, 0, 0, 1, 0, 0, 0, -1));
        vq.push_back(mk("done",      0, -1, 0, -1, -1, 0, 0, 0, 1, 1, 0, 0, -1));
        vq.push_back(mk("done_ld",   0,  0, 0, -1, -1, 0, 0, 0, 1, 1, 0, 0, -1));
        vq.push_back(mk("reload",    0, -1, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        // two rows, flush, then a full reload that must land at row0..row3
        vq.push_back(mk("fl_ld_a", 0, 8, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        vq.push_back(mk("fl_ld_b", 0, 8, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        vq.push_back(mk("flush",   1, -1, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        for (int i = 0; i < SIZE; i++)
            vq.push_back(mk($sformatf("q_ld%0d", i), 0, 4 + i, 0, -1, -1, 0, 1, 0, 0, 0, 0, 0, -1));
        vq.push_back(mk("start2",  0, -1, 0,  0, -1, 0, 0, 1, 1, 0, 0, 0, -1));
        vq.push_back(mk("q_rd0",   0, -1, 0,  1, -1, 0, 0, 0, 1, 0, 0, 0, 4));
        vq.push_back(mk("q_rd1",   0, -1, 0,  2, -1, 0, 0, 0, 1, 0, 0, 1, 5));
        vq.push_back(mk("q_rd2",   0, -1, 0,  3, -1, 0, 0, 0, 1, 0, 0, 2, 6));
        vq.push_back(mk("q_rd3",   0, -1, 0, -1, -1, 0, 0, 0, 1, 0, 0, 3, 7));
        vq.push_back(mk("rd_idle", 0, -1, 0, -1, -1, 0, 0, 0, 1, 0, 0, 0, -1));

        rst_ni = 1'b0; flush_i = 1'b0; ld_valid_i = 1'b0; ld_row_i = '0; lu_busy_i = 1'b0;
        rd_valid_i = 1'b0; rd_addr_i = '0; wr_valid_i = 1'b0; wr_addr_i = '0; wr_row_i = '0;
        cyc();
        cyc();
        chk("rst/ld_ready", ld_ready_o, 0);
        chk("rst/start", start_o, 0);
        chk("rst/rd_valid", rd_valid_o, 0);
        chk("rst/rd_row", rd_row_o, 0);
        chk("rst/rd_addr", rd_addr_o, 0);
        chk("rst/done", done_o, 0);
        chk("rst/err", err_o, 0);
        rst_ni = 1'b1;
        cyc();

        foreach (vq[k]) apply(vq[k]);

        // lu write during LOAD: dropped, err set and sticky across flush
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 0; wr_row_i = rows[8];
        @(negedge clk_i);
        chk("err/wr_ready_load", wr_ready_o, 0);
        chk("err/before", err_o, 0);
        cyc();
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b1; rd_addr_i = 0;
        @(negedge clk_i);
        chk("err/set", err_o, 1);
        cyc();
        rd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("err/row_unchanged", rd_row_o, rows[4]);
        cyc();
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("err/sticky", err_o, 1);

        // reload, enter RUN with a read in flight, then reset
        for (int i = 0; i < SIZE; i++) begin
            ld_valid_i = 1'b1; ld_row_i = rows[4 + i];
            cyc();
        end
        ld_valid_i = 1'b0;
        cyc();
        lu_busy_i = 1'b1; rd_valid_i = 1'b1; rd_addr_i = 2;
        cyc();
        rst_ni = 1'b0; rd_addr_i = 3;
        @(negedge clk_i);
        chk("mid_run/rd_valid", rd_valid_o, 1);
        chk("mid_run/rd_row", rd_row_o, rows[6]);
        cyc();
        chk("rst2/ld_ready", ld_ready_o, 0);
        chk("rst2/start", start_o, 0);
        chk("rst2/rd_valid", rd_valid_o, 0);
        chk("rst2/rd_row", rd_row_o, 0);
        chk("rst2/rd_addr", rd_addr_o, 0);
        chk("rst2/done", done_o, 0);
        chk("rst2/err", err_o, 0);
        chk("rst2/wr_ready", wr_ready_o, 0);
        rst_ni = 1'b1; rd_valid_i = 1'b0; lu_busy_i = 1'b0;
        cyc();
        chk("post_rst/ld_ready", ld_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
